if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line: name, default, meaning.
- PC_RESET, 32'h0000_3000, first fetch address.
- PC_FLUSH, 32'h0000_4180, fetch address after a flush.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- flush  in  1  clear IF/ID, redirect to PC_FLUSH.
- npc_sel  in  2  0 PC+4, 1 br_target, 2 j_target, 3 jr_target.
- br_target  in  32  branch target, computed in ID.
- j_target  in  32  jump target, computed in ID.
- jr_target  in  32  register jump target.
- imem_addr  out  32  current PC, to instruction memory (combinational read).
- imem_rdata  in  32  instruction at imem_addr.
- if_id_instr  out  32  latched instruction; its [15:0] feeds the immediate extender.
- if_id_pc4  out  32  latched PC+4.
- if_id_valid  out  1  latched slot holds a real instruction.
- align_err  out  1  sticky misaligned-target flag.
- fetch_cnt  out  32  count of accepted fetches.

Function
REQ-004 imem_addr SHALL equal the PC register combinationally.
REQ-005 Each cycle, with no stall and no flush, the IF/ID register SHALL load {imem_rdata, PC+4, 1} and the PC SHALL load the npc_sel-selected next PC.
REQ-006 Fetch latency SHALL be one cycle: an instruction at address A is visible on if_id_instr the cycle after PC==A.
REQ-007 Branch delay slots SHALL be architectural: a redirect through npc_sel does not squash the instruction fetched in the same cycle.
REQ-008 While stall=1 and flush=0, the PC and all IF/ID fields SHALL hold, npc_sel SHALL be ignored, and fetch_cnt SHALL hold.
REQ-009 When flush=1, the block SHALL take these actions, regardless of stall and npc_sel:
- IF/ID loads {32'h0, 32'h0, 0}.
- PC loads PC_FLUSH.
- fetch_cnt holds.
REQ-010 Priority SHALL be reset > flush > stall > normal.
REQ-011 PC+4 SHALL be 32-bit modulo addition; 32'hFFFF_FFFC+4 wraps to 0 with no error.
REQ-012 If the selected next PC has bits [1:0] != 0 in a cycle where the PC would update, the PC SHALL load the target with bits [1:0] forced to 00, and align_err SHALL set and remain 1 until reset.
REQ-013 fetch_cnt SHALL increment by 1 on each cycle where IF/ID loads a valid instruction, and SHALL wrap modulo 2^32.
REQ-014 Outputs SHALL be registered except imem_addr, which SHALL be PC.

Reset
REQ-015 On reset, the block SHALL set:
- PC = PC_RESET.
- if_id_instr = 0 (nop) and if_id_pc4 = 0.
- if_id_valid = 0, align_err = 0, fetch_cnt = 0.
REQ-016 Reset mid-stall or mid-flush SHALL take effect in the same edge; the first post-reset cycle SHALL present PC_RESET on imem_addr.

Structure
REQ-017 A shared package SHALL hold:
- NPC_* encodings: PC4=0, BR=1, J=2, JR=3.
- NOP=32'h0.
- The PC_RESET and PC_FLUSH defaults.
REQ-018 Next-PC selection SHALL be one combinational sub-module, npc_mux, with 4:1 selection, 32-bit width.
REQ-019 The PC register and the IF/ID register SHALL be in the top module.

Verification
REQ-020 Reset, then free-run with npc_sel=0 and memory returning addr ^ 32'hA5A5_0000 -> imem_addr goes 3000, 3004, 3008; if_id_instr lags by one cycle; fetch_cnt=3 after 3 fetch cycles.
REQ-021 At PC=300C, set npc_sel=1 with br_target=3100 for 1 cycle -> the delay-slot instruction at 300C is latched valid; next imem_addr is 3100.
REQ-022 Assert stall for 2 cycles at PC=3010 -> PC, if_id_* and fetch_cnt are frozen 2 cycles; normal flow resumes at 3014.
REQ-023 Assert stall=1 and flush=1 together, with npc_sel=2 -> if_id_valid=0, if_id_instr=0, next PC=4180, fetch_cnt unchanged.
REQ-024 npc_sel=3 with jr_target=3102 -> PC=3100, align_err=1 and sticky through later fetches; assert reset -> align_err=0, PC=3000.
REQ-025 Force PC to FFFF_FFFC via jr, then npc_sel=0 -> PC=0000_0000, align_err unchanged, if_id_pc4=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared encodings and defaults for the instruction fetch stage
package if_stage_pkg;

  // Next-PC source select encodings
  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_FLUSH_DEFAULT = 32'h0000_4180;

  // Force a byte address down to its enclosing word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_npc_mux.sv
// rtl/if_stage_npc_mux.sv - 4:1 combinational next-PC selector
module npc_mux
  import if_stage_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] pc4,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  // Pick the next fetch address from the sequential or redirect sources
  always_comb begin
    npc = pc4;
    case (sel)
      NPC_PC4: npc = pc4;
      NPC_BR:  npc = br_target;
      NPC_J:   npc = j_target;
      NPC_JR:  npc = jr_target;
      default: npc = pc4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, next-PC select and IF/ID latch
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] PC_FLUSH = PC_FLUSH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        align_err,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] npc;
  logic        npc_misaligned;

  // PC+4 wraps naturally at the top of the address space
  assign pc4            = pc + 32'd4;
  assign imem_addr      = pc;
  assign npc_misaligned = |npc[1:0];

  npc_mux u_npc_mux (
    .sel       (npc_sel),
    .pc4       (pc4),
    .br_target (br_target),
    .j_target  (j_target),
    .jr_target (jr_target),
    .npc       (npc)
  );

  // PC and IF/ID update with priority reset > flush > stall > fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      if_id_instr <= NOP;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      align_err   <= 1'b0;
      fetch_cnt   <= 32'h0;
    end else if (flush) begin
      pc          <= PC_FLUSH;
      if_id_instr <= NOP;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      // The slot fetched this cycle is kept even on a redirect (delay slot)
      pc          <= word_align(npc);
      if_id_instr <= imem_rdata;
      if_id_pc4   <= pc4;
      if_id_valid <= 1'b1;
      fetch_cnt   <= fetch_cnt + 32'd1;
      if (npc_misaligned) begin
        align_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a behavioural model
module tb_if_stage;

  localparam logic [31:0] K        = 32'hA5A5_0000;
  localparam logic [31:0] PC_RST   = 32'h0000_3000;
  localparam logic [31:0] PC_FLS   = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  npc_sel = 2'd0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] j_target = 32'h0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        align_err;
  logic [31:0] fetch_cnt;

  int unsigned passed = 0;
  int unsigned total = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_err;

  if_stage #(.PC_RESET(PC_RST), .PC_FLUSH(PC_FLS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .npc_sel(npc_sel),
    .br_target(br_target), .j_target(j_target), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .align_err(align_err),
    .fetch_cnt(fetch_cnt)
  );

  assign imem_rdata = imem_addr ^ K;

  always #5 clk = ~clk;

  task automatic step();
    logic [31:0] tgt;
    @(posedge clk);
    if (reset) begin
      m_pc = PC_RST; m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else if (flush) begin
      m_pc = PC_FLS; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (!stall) begin
      case (npc_sel)
        2'd0: tgt = m_pc + 4;
        2'd1: tgt = br_target;
        2'd2: tgt = j_target;
        default: tgt = jr_target;
      endcase
      m_instr = m_pc ^ K;
      m_pc4 = m_pc + 4;
      m_valid = 1;
      m_cnt = m_cnt + 1;
      if (tgt % 4 != 0) m_err = 1;
      m_pc = tgt - (tgt % 4);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; flush = 1;
    step(); step();
    reset = 0; stall = 0; flush = 0; npc_sel = 0;
    total++; if (imem_addr !== PC_RST) $display("FAIL reset_pc got %h want %h", imem_addr, PC_RST); else passed++;
    total++; if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) $display("FAIL reset_ifid got %h/%h want 0/0", if_id_instr, if_id_pc4); else passed++;
    total++; if ({if_id_valid, align_err} !== 2'b00) $display("FAIL reset_flags got %b%b want 00", if_id_valid, align_err); else passed++;
    total++; if (fetch_cnt !== 32'h0) $display("FAIL reset_cnt got %0d want 0", fetch_cnt); else passed++;
  endtask

  task automatic test_free_run();
    npc_sel = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (imem_addr !== PC_RST + 4 * i) $display("FAIL run_addr got %h want %h", imem_addr, PC_RST + 4 * i); else passed++;
      total++; if (if_id_instr !== ((PC_RST + 4 * (i - 1)) ^ K)) $display("FAIL run_instr got %h want %h", if_id_instr, (PC_RST + 4 * (i - 1)) ^ K); else passed++;
    end
    total++; if (fetch_cnt !== 32'd3) $display("FAIL run_cnt got %0d want 3", fetch_cnt); else passed++;
  endtask

  task automatic test_branch();
    npc_sel = 1; br_target = 32'h3100;
    step();
    npc_sel = 0;
    total++; if (if_id_instr !== (32'h300C ^ K) || if_id_valid !== 1'b1) $display("FAIL delay_slot got %h v%b want %h v1", if_id_instr, if_id_valid, 32'h300C ^ K); else passed++;
    total++; if (if_id_pc4 !== 32'h3010) $display("FAIL delay_pc4 got %h want 3010", if_id_pc4); else passed++;
    total++; if (imem_addr !== 32'h3100) $display("FAIL branch_addr got %h want 3100", imem_addr); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] cnt0, instr0;
    npc_sel = 2; j_target = 32'h3010;
    step();
    npc_sel = 3; jr_target = 32'h5000; stall = 1;
    cnt0 = m_cnt; instr0 = 32'h3100 ^ K;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (imem_addr !== 32'h3010) $display("FAIL stall_pc got %h want 3010", imem_addr); else passed++;
      total++; if (if_id_instr !== instr0 || fetch_cnt !== cnt0) $display("FAIL stall_hold got %h/%0d want %h/%0d", if_id_instr, fetch_cnt, instr0, cnt0); else passed++;
    end
    stall = 0; npc_sel = 0;
    step();
    total++; if (imem_addr !== 32'h3014 || if_id_instr !== (32'h3010 ^ K)) $display("FAIL stall_resume got %h/%h want 3014/%h", imem_addr, if_id_instr, 32'h3010 ^ K); else passed++;
    total++; if (fetch_cnt !== cnt0 + 1) $display("FAIL stall_cnt got %0d want %0d", fetch_cnt, cnt0 + 1); else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] cnt0;
    cnt0 = m_cnt;
    stall = 1; flush = 1; npc_sel = 2; j_target = 32'h7770;
    step();
    stall = 0; flush = 0; npc_sel = 0;
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) $display("FAIL flush_ifid got v%b %h %h want v0 0 0", if_id_valid, if_id_instr, if_id_pc4); else passed++;
    total++; if (imem_addr !== PC_FLS) $display("FAIL flush_pc got %h want %h", imem_addr, PC_FLS); else passed++;
    total++; if (fetch_cnt !== cnt0) $display("FAIL flush_cnt got %0d want %0d", fetch_cnt, cnt0); else passed++;
  endtask

  task automatic test_align();
    npc_sel = 3; jr_target = 32'h3102;
    step();
    npc_sel = 0;
    total++; if (imem_addr !== 32'h3100 || align_err !== 1'b1) $display("FAIL align_set got %h e%b want 3100 e1", imem_addr, align_err); else passed++;
    step(); step();
    total++; if (align_err !== 1'b1) $display("FAIL align_sticky got %b want 1", align_err); else passed++;
    reset = 1;
    step();
    reset = 0;
    total++; if (align_err !== 1'b0 || imem_addr !== PC_RST) $display("FAIL align_reset got e%b %h want e0 %h", align_err, imem_addr, PC_RST); else passed++;
  endtask

  task automatic test_wrap();
    logic err0;
    err0 = m_err;
    npc_sel = 3; jr_target = 32'hFFFF_FFFC;
    step();
    npc_sel = 0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_jr got %h want fffffffc", imem_addr); else passed++;
    step();
    total++; if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0) $display("FAIL wrap_pc got %h/%h want 0/0", imem_addr, if_id_pc4); else passed++;
    total++; if (align_err !== err0) $display("FAIL wrap_err got %b want %b", align_err, err0); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      npc_sel   = 2'($urandom_range(0, 3));
      br_target = ($urandom_range(0, 7) == 0) ? $urandom : {16'h0, 4'h3, 10'($urandom), 2'b00};
      j_target  = ($urandom_range(0, 7) == 0) ? $urandom : {16'h0, 4'h3, 10'($urandom), 2'b00};
      jr_target = ($urandom_range(0, 7) == 0) ? $urandom : {16'h0, 4'h3, 10'($urandom), 2'b00};
      step();
      total++; if (imem_addr !== m_pc) $display("FAIL rnd_pc[%0d] got %h want %h", i, imem_addr, m_pc); else passed++;
      total++; if (if_id_instr !== m_instr) $display("FAIL rnd_instr[%0d] got %h want %h", i, if_id_instr, m_instr); else passed++;
      total++; if (if_id_pc4 !== m_pc4) $display("FAIL rnd_pc4[%0d] got %h want %h", i, if_id_pc4, m_pc4); else passed++;
      total++; if (if_id_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b want %b", i, if_id_valid, m_valid); else passed++;
      total++; if (align_err !== m_err) $display("FAIL rnd_err[%0d] got %b want %b", i, align_err, m_err); else passed++;
      total++; if (fetch_cnt !== m_cnt) $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, fetch_cnt, m_cnt); else passed++;
    end
    reset = 0; flush = 0; stall = 0; npc_sel = 0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_stall();
    test_flush();
    test_align();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
